// File: rtl/march_bist_engine.sv
// March C- / March LR BIST engine driving a single-port synchronous SRAM.
// Define FAIL_LOG_EN to add first-miscompare capture ports (FailAddr/FailData/FailElem).
module march_bist_engine #(
  parameter  int unsigned DEPTH  = 256,
  parameter  int unsigned DATA_W = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Mode,
  output logic              Busy,
  output logic              Done,
  output logic              GoNoGo,
  output logic              MemCE,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData
`ifdef FAIL_LOG_EN
  ,
  output logic [ADDR_W-1:0] FailAddr,
  output logic [DATA_W-1:0] FailData,
  output logic [2:0]        FailElem
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [2:0]        elem_q, elem_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ce_q, ce_d;
  logic              we_q, we_d;
  logic              val_q, val_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              gonogo_q, gonogo_d;
  logic              fail_q, fail_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_exp_q, rd_exp_d;
  logic              mismatch;
  logic              down;
  logic [ADDR_W-1:0] addr_end;
`ifdef FAIL_LOG_EN
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]        rd_elem_q, rd_elem_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
`endif

  function automatic logic [1:0] op_last(input logic mode, input logic [2:0] elem);
    case (elem)
      3'd0, 3'd5: op_last = 2'd0;
      3'd2, 3'd4: op_last = mode ? 2'd3 : 2'd1;
      default:    op_last = 2'd1;
    endcase
  endfunction

  function automatic logic elem_down(input logic mode, input logic [2:0] elem);
    elem_down = mode ? (elem == 3'd1) : ((elem == 3'd3) || (elem == 3'd4));
  endfunction

  // Returns {is_write, data bit}. Middle elements follow r(v), w(~v), r(~v), w(v)
  // where v is the element's first read value.
  function automatic logic [1:0] op_kind(input logic mode, input logic [2:0] elem,
                                         input logic [1:0] op);
    logic rv;
    rv = mode ? ((elem == 3'd2) || (elem == 3'd3)) : ~elem[0];
    case (elem)
      3'd0:    op_kind = 2'b10;
      3'd5:    op_kind = 2'b00;
      default: op_kind = {op[0], rv ^ op[0] ^ op[1]};
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    elem_d   = elem_q;
    op_d     = op_q;
    addr_d   = addr_q;
    ce_d     = ce_q;
    we_d     = we_q;
    val_d    = val_q;
    busy_d   = busy_q;
    done_d   = done_q;
    gonogo_d = gonogo_q;
    mismatch = rd_vld_q && (MemRData != {DATA_W{rd_exp_q}});
    fail_d   = fail_q | mismatch;
    // Read issued this cycle: its data arrives next cycle, compare then.
    rd_vld_d = ce_q & ~we_q;
    rd_exp_d = val_q;
    down     = elem_down(mode_q, elem_q);
    addr_end = down ? '0 : LAST_ADDR;
`ifdef FAIL_LOG_EN
    rd_addr_d   = addr_q;
    rd_elem_d   = elem_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_elem_d = fail_elem_q;
    if (mismatch && !fail_q) begin
      fail_addr_d = rd_addr_q;
      fail_data_d = MemRData;
      fail_elem_d = rd_elem_q;
    end
`endif
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d  = RUN;
          mode_d   = Mode;
          elem_d   = '0;
          op_d     = '0;
          addr_d   = '0;
          ce_d     = 1'b1;
          we_d     = 1'b1;
          val_d    = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          gonogo_d = 1'b0;
          fail_d   = 1'b0;
`ifdef FAIL_LOG_EN
          fail_addr_d = '0;
          fail_data_d = '0;
          fail_elem_d = '0;
`endif
        end
      end
      RUN: begin
        if (op_q != op_last(mode_q, elem_q)) begin
          op_d = op_q + 2'd1;
        end else if (addr_q != addr_end) begin
          op_d   = '0;
          addr_d = down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end else if (elem_q != 3'd5) begin
          elem_d = elem_q + 3'd1;
          op_d   = '0;
          addr_d = elem_down(mode_q, elem_d) ? LAST_ADDR : '0;
        end else begin
          state_d = DRAIN;
          ce_d    = 1'b0;
          we_d    = 1'b0;
        end
        if (state_d == RUN) begin
          {we_d, val_d} = op_kind(mode_q, elem_d, op_d);
        end
      end
      DRAIN: begin
        state_d  = DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        gonogo_d = ~fail_d;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      elem_q   <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      val_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gonogo_q <= 1'b0;
      fail_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_exp_q <= 1'b0;
`ifdef FAIL_LOG_EN
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      fail_elem_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      elem_q   <= elem_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      ce_q     <= ce_d;
      we_q     <= we_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      gonogo_q <= gonogo_d;
      fail_q   <= fail_d;
      rd_vld_q <= rd_vld_d;
      rd_exp_q <= rd_exp_d;
`ifdef FAIL_LOG_EN
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_elem_q <= fail_elem_d;
`endif
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign GoNoGo   = gonogo_q;
  assign MemCE    = ce_q;
  assign MemWE    = we_q;
  assign MemAddr  = addr_q;
  assign MemWData = {DATA_W{val_q}};
`ifdef FAIL_LOG_EN
  assign FailAddr = fail_addr_q;
  assign FailData = fail_data_q;
  assign FailElem = fail_elem_q;
`endif

endmodule

// File: tb/tb_march_bist_engine.sv
// Bench for march_bist_engine: a 256x4 and a 5x8 instance, each with an SRAM model
// that can carry one stuck-at bit, checked against a March-notation reference model.
module tb_march_bist_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode, sel;
  logic f_en, f_val;
  int   f_addr, f_bit;
  int   checks = 0;
  int   errors = 0;

  logic       a_busy, a_done, a_gng, a_ce, a_we;
  logic [7:0] a_addr;
  logic [3:0] a_wd, a_rd;
  logic       b_busy, b_done, b_gng, b_ce, b_we;
  logic [2:0] b_addr;
  logic [7:0] b_wd, b_rd;
`ifdef FAIL_LOG_EN
  logic [7:0] a_faddr; logic [3:0] a_fdata; logic [2:0] a_felem;
  logic [2:0] b_faddr; logic [7:0] b_fdata; logic [2:0] b_felem;
`endif

  march_bist_engine #(.DEPTH(256), .DATA_W(4)) dut_a (
    .Clock(clk), .Reset(rst), .Start(start & ~sel), .Mode(mode),
    .Busy(a_busy), .Done(a_done), .GoNoGo(a_gng), .MemCE(a_ce), .MemWE(a_we),
    .MemAddr(a_addr), .MemWData(a_wd), .MemRData(a_rd)
`ifdef FAIL_LOG_EN
    , .FailAddr(a_faddr), .FailData(a_fdata), .FailElem(a_felem)
`endif
  );

  march_bist_engine #(.DEPTH(5), .DATA_W(8)) dut_b (
    .Clock(clk), .Reset(rst), .Start(start & sel), .Mode(mode),
    .Busy(b_busy), .Done(b_done), .GoNoGo(b_gng), .MemCE(b_ce), .MemWE(b_we),
    .MemAddr(b_addr), .MemWData(b_wd), .MemRData(b_rd)
`ifdef FAIL_LOG_EN
    , .FailAddr(b_faddr), .FailData(b_fdata), .FailElem(b_felem)
`endif
  );

  function automatic logic [7:0] inj(input logic [7:0] d, input int a);
    logic [7:0] r;
    r = d;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [3:0] mem_a [256];
  logic [7:0] mem_b [5];
  always @(posedge clk) begin
    if (a_ce) begin
      if (a_we) mem_a[a_addr] <= a_wd;
      else      a_rd <= 4'(inj({4'd0, mem_a[a_addr]}, int'(a_addr)));
    end
    if (b_ce && b_addr < 3'd5) begin
      if (b_we) mem_b[b_addr] <= b_wd;
      else      b_rd <= inj(mem_b[b_addr], int'(b_addr));
    end
  end

  logic       s_busy, s_done, s_gng, s_ce, s_we;
  logic [7:0] s_addr, s_wd, s_faddr, s_fdata;
  logic [2:0] s_felem;
  always_comb begin
    s_faddr = '0; s_fdata = '0; s_felem = '0;
    if (sel) begin
      s_busy = b_busy; s_done = b_done; s_gng = b_gng; s_ce = b_ce; s_we = b_we;
      s_addr = {5'd0, b_addr}; s_wd = b_wd;
`ifdef FAIL_LOG_EN
      s_faddr = {5'd0, b_faddr}; s_fdata = b_fdata; s_felem = b_felem;
`endif
    end else begin
      s_busy = a_busy; s_done = a_done; s_gng = a_gng; s_ce = a_ce; s_we = a_we;
      s_addr = a_addr; s_wd = {4'd0, a_wd};
`ifdef FAIL_LOG_EN
      s_faddr = a_faddr; s_fdata = {4'd0, a_fdata}; s_felem = a_felem;
`endif
    end
  end

  typedef struct { bit we; int addr; bit val; int elem; } op_t;
  op_t exp_ops[$];

  // Expand March notation into the flat op list the engine must issue.
  function automatic void build_ops(input bit m, input int depth);
    string dirs, s;
    string el[6];
    int a;
    op_t o;
    exp_ops.delete();
    if (!m) begin
      dirs = "UUUDDU"; el = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
    end else begin
      dirs = "UDUUUU"; el = '{"w0", "r0w1", "r1w0r0w1", "r1w0", "r0w1r1w0", "r0"};
    end
    for (int e = 0; e < 6; e++) begin
      s = el[e];
      for (int i = 0; i < depth; i++) begin
        a = (dirs[e] == "D") ? depth - 1 - i : i;
        for (int j = 0; j < s.len(); j += 2) begin
          o.we = (s[j] == "w"); o.val = (s[j+1] == "1"); o.addr = a; o.elem = e;
          exp_ops.push_back(o);
        end
      end
    end
  endfunction

  function automatic void predict(input logic [7:0] mask, output bit pass,
                                  output int faddr, output int fdata, output int felem);
    logic [7:0] mm [256];
    logic [7:0] rd;
    pass = 1; faddr = 0; fdata = 0; felem = 0;
    foreach (exp_ops[i]) begin
      if (exp_ops[i].we) mm[exp_ops[i].addr] = exp_ops[i].val ? mask : 8'h00;
      else begin
        rd = inj(mm[exp_ops[i].addr], exp_ops[i].addr) & mask;
        if (pass && rd !== (exp_ops[i].val ? mask : 8'h00)) begin
          pass = 0; faddr = exp_ops[i].addr; fdata = int'(rd); felem = exp_ops[i].elem;
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run(input string nm, input bit s, input bit m, input int restart_at,
                     input int reset_at, input int exp_done, input bit exp_pass,
                     input int exp_faddr, input int exp_fdata, input int exp_felem);
    int depth, cyc, idx, seq_bad, oob, busy_bad;
    logic [7:0] mask;
    depth = s ? 5 : 256;
    mask  = s ? 8'hFF : 8'h0F;
    idx = 0; seq_bad = 0; oob = 0; busy_bad = 0;
    sel = s;
    build_ops(m, depth);
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; mode = ~m;
    chk({nm, ".k1_busy"}, 32'(s_busy), 1);
    chk({nm, ".k1_done"}, 32'(s_done), 0);
    chk({nm, ".k1_gonogo"}, 32'(s_gng), 0);
    chk({nm, ".k1_ce"}, 32'(s_ce), 1);
    for (cyc = 1; cyc < 5000; cyc++) begin
      if (s_done === 1'b1) break;
      if (reset_at == cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({nm, ".rst_ce"}, 32'(s_ce), 0);
        chk({nm, ".rst_busy"}, 32'(s_busy), 0);
        chk({nm, ".rst_done"}, 32'(s_done), 0);
        return;
      end
      start = (restart_at == cyc);
      if (s_busy !== 1'b1 || s_gng !== 1'b0) busy_bad++;
      if (s_ce === 1'b1) begin
        if (idx >= exp_ops.size() || s_we !== exp_ops[idx].we ||
            int'(s_addr) !== exp_ops[idx].addr ||
            (s_we && s_wd !== (exp_ops[idx].val ? mask : 8'h00)))
          seq_bad++;
        if (int'(s_addr) >= depth) oob++;
        idx++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, ".done_cycle"}, 32'(cyc), 32'(exp_done));
    chk({nm, ".ce_cycles"}, 32'(idx), 32'(exp_done - 2));
    chk({nm, ".op_seq_bad"}, 32'(seq_bad), 0);
    chk({nm, ".busy_gonogo_bad"}, 32'(busy_bad), 0);
    chk({nm, ".gonogo"}, 32'(s_gng), 32'(exp_pass));
    chk({nm, ".busy_end"}, 32'(s_busy), 0);
    if (s) chk({nm, ".addr_oob"}, 32'(oob), 0);
`ifdef FAIL_LOG_EN
    chk({nm, ".fail_addr"}, 32'(s_faddr), 32'(exp_faddr));
    chk({nm, ".fail_data"}, 32'(s_fdata), 32'(exp_fdata));
    chk({nm, ".fail_elem"}, 32'(s_felem), 32'(exp_felem));
`else
    if (exp_faddr < 0 || exp_fdata < 0 || exp_felem < 0) chk({nm, ".fail_args"}, 0, 1);
`endif
  endtask

  typedef struct {
    bit s; bit m; bit fen; int fa; int fb; bit fv;
    int done; bit pass; int faddr; int fdata; int felem;
  } vec_t;
  vec_t tbl[8];

  initial begin
    bit   pass;
    int   fa, fd, fe, depth;
    bit   s, m;
    rst = 1'b1; start = 1'b0; mode = 1'b0; sel = 1'b0;
    f_en = 1'b0; f_val = 1'b0; f_addr = 0; f_bit = 0;
    repeat (3) @(negedge clk);
    chk("reset.a_busy_done_gng", {a_busy, a_done, a_gng}, 0);
    chk("reset.a_ce_we", {a_ce, a_we}, 0);
    chk("reset.a_addr_wd", {a_addr, a_wd}, 0);
    chk("reset.b_busy_done_gng", {b_busy, b_done, b_gng}, 0);
    chk("reset.b_ce_we_addr_wd", {b_ce, b_we, b_addr, b_wd}, 0);
    rst = 1'b0;

    tbl[0] = '{0, 0, 0, 0,    0, 0, 2562, 1, 0,    0,    0};
    tbl[1] = '{0, 0, 1, 'h37, 2, 0, 2562, 0, 'h37, 'hB,  2};
    tbl[2] = '{0, 1, 0, 0,    0, 0, 3586, 1, 0,    0,    0};
    tbl[3] = '{0, 1, 1, 'h37, 2, 0, 3586, 0, 'h37, 'hB,  2};
    tbl[4] = '{0, 0, 1, 0,    0, 1, 2562, 0, 0,    'h1,  1};
    tbl[5] = '{1, 0, 0, 0,    0, 0, 52,   1, 0,    0,    0};
    tbl[6] = '{1, 1, 0, 0,    0, 0, 72,   1, 0,    0,    0};
    tbl[7] = '{1, 1, 1, 4,    7, 1, 72,   0, 4,    'h80, 1};
    for (int i = 0; i < 8; i++) begin
      f_en = tbl[i].fen; f_addr = tbl[i].fa; f_bit = tbl[i].fb; f_val = tbl[i].fv;
      run($sformatf("vec%0d", i), tbl[i].s, tbl[i].m, 0, 0, tbl[i].done, tbl[i].pass,
          tbl[i].faddr, tbl[i].fdata, tbl[i].felem);
    end

    f_en = 1'b0;
    run("rst_mid", 0, 0, 0, 500, 0, 0, 0, 0, 0);
    run("after_rst", 0, 0, 0, 0, 2562, 1, 0, 0, 0);
    run("restart_in_run", 0, 0, 100, 0, 2562, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("done_hold", {s_done, s_gng, s_busy}, 3'b110);
    run("restart_lr", 0, 1, 0, 0, 3586, 1, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      s = (r % 2 == 0);
      m = 1'($urandom_range(0, 1));
      depth = s ? 5 : 256;
      f_en = ($urandom_range(0, 3) != 0);
      f_addr = $urandom_range(0, depth - 1);
      f_bit = $urandom_range(0, s ? 7 : 3);
      f_val = 1'($urandom_range(0, 1));
      build_ops(m, depth);
      predict(s ? 8'hFF : 8'h0F, pass, fa, fd, fe);
      run($sformatf("rand%0d", r), s, m, 0, 0, (m ? 14 : 10) * depth + 2, pass, fa, fd, fe);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
